mips32_fetch_queue: RTL and testbench
=====================================

# mips32_fetch_queue

Instruction fetch front-end for the Pipelined_MIPS32 core. Owns the fetch PC, issues word reads to instruction memory (fixed 1-cycle read latency) and buffers returned instructions in a small FIFO. Delivers instruction/NPC pairs to the IF/ID boundary over a valid/ready handshake. Supports branch redirect with flush of buffered and in-flight words, plus optional HLT-based fetch stop.

## Interface
- ADDR_W, 32, PC width; word-addressed, so NPC = PC + 1.
- DATA_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

- clk1  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address; valid while imem_req is high.
- imem_rdata  in  DATA_W  read data; valid exactly one cycle after the request.
- redirect_valid  in  1  taken branch: flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_instr  out  DATA_W  head instruction.
- out_npc  out  ADDR_W  address of the head instruction + 1.
- fetch_stopped  out  1  HLT captured; no further requests.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- State: pc, inflight flag, inflight_pc, kill flag, FIFO, FSM {RUN, STOPPED}.
- Issue rule: imem_req = (state==RUN) && !redirect_valid && (count + inflight < DEPTH). This is credit-based, so a returning word always has a free slot. The rule ignores a same-cycle dequeue.
- On issue: imem_addr = pc. Then pc <= pc+1, inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- Response: in the cycle after an issue, if kill is low, push {imem_rdata, inflight_pc+1}.
- Dequeue: pop when out_valid && out_ready.
- Redirect, which has priority over everything:
  - Clear the FIFO and set kill for any in-flight word.
  - Set pc <= redirect_pc and state <= RUN, clearing fetch_stopped.
  - Issue nothing in the redirect cycle.
  - A same-cycle out handshake is still a valid consumption; the consumer must ignore the popped word if its own branch logic requires.
- kill clears automatically the cycle after the discarded response.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFF wraps to 0x00000000.
- Simultaneous push and pop on a full FIFO cannot occur, because credits prevent it. Simultaneous push and pop at any other level leaves count unchanged.

## Timing
- Reset values: pc=0, FIFO empty, count=0, inflight=0, kill=0, state=RUN; outputs imem_req=0 during reset, out_valid=0, out_instr=0, out_npc=0, fetch_stopped=0.
- Reset deasserted before edge E0: request for addr 0 in cycle 0.
- Word from addr 0 is pushed at the end of cycle 1; out_valid first seen in cycle 2. Fetch-to-valid latency is 2 cycles.
- Steady state with out_ready=1: one instruction per cycle.
- Redirect in cycle R: out_valid=0 in R+1, request for redirect_pc in R+1, valid in R+3.
- Reset mid-operation: immediate return to reset values; in-flight data is dropped.

## Configuration
- FETCH_HLT_STOP_EN defined:
  - A pushed word whose bits [31:26] equal OPC_HLT (6'h3f) is enqueued normally, then state <= STOPPED and fetch_stopped=1.
  - A word issued in the same cycle as the HLT response is killed.
  - No requests are issued in STOPPED.
  - Only redirect or reset leaves STOPPED.
- FETCH_HLT_STOP_EN undefined: HLT is an ordinary word, fetch never stops, and fetch_stopped is tied to 0.

## Structure
- Shared package mips32_pkg holds:
  - XLEN=32;
  - opcode constants, including OPC_HLT=6'h3f, OPC_ADDI=6'h0a, OPC_LW=6'h08, OPC_SW=6'h09;
  - instr_t, a 32-bit typedef;
  - fetch_entry_t = {instr, npc}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH deep, with push/pop/count and a flush input.
- FSM, credit and kill logic stay in the top module.

## Test plan
- Reset, imem[0..3] = 28010078, 0c631800, 20220000, 0c631800; out_ready=1:
  - out_valid first rises in cycle 2;
  - instr/npc pairs come out as (28010078,1), (0c631800,2), (20220000,3), (0c631800,4) on consecutive cycles.
- Back-pressure: out_ready=0 for 10 cycles, then 1:
  - count saturates at 4, with no request while count+inflight=4;
  - the next 4 outputs are addresses 0..3 in order, with no loss or duplication.
- Redirect to 0x40 in cycle 5 while the FIFO holds 3 words and one is in flight:
  - out_valid=0 in cycle 6;
  - request addr 0x40 in cycle 6;
  - first output has npc 0x41 in cycle 8;
  - no stale word appears.
- FETCH_HLT_STOP_EN, imem[7]=fc000000:
  - outputs addresses 0..7, then fetch_stopped=1;
  - no requests beyond addr 8, and the addr-8 word is never output.
  - A redirect to 0 then restarts fetch and clears fetch_stopped.
- Wrap: redirect to 0xFFFFFFFF → outputs npc 0x00000000, then the next request is addr 0.
- Assert rst_n low mid-stream with a word in flight → all outputs are at reset values immediately; after release, fetch restarts at addr 0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction and fetch-entry types.
package mips32_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h08;
  localparam logic [5:0] OPC_SW    = 6'h09;
  localparam logic [5:0] OPC_ADDI  = 6'h0a;
  localparam logic [5:0] OPC_HLT   = 6'h3f;

  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    instr_t            instr;
    logic [XLEN-1:0]   npc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input instr_t i);
    return i[31:26];
  endfunction

endpackage

// File: rtl/mips32_fetch_queue_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush wins over push and pop.
module fetch_fifo
  import mips32_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the top masks the head while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 fetch front-end: PC, credit-based imem requests, fetch FIFO, redirect.
// Optional HLT fetch stop is built when FETCH_HLT_STOP_EN is defined.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_npc,
  output logic              fetch_stopped,
  output logic [CW-1:0]     count
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_kill;
  fetch_state_t      r_state;

  logic              w_credit_ok;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_hlt;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // A request only goes out when a slot is reserved for its response, so a
  // returning word never meets a full FIFO even if nothing dequeues.
  assign w_credit_ok = ({1'b0, w_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);
  assign w_issue     = (r_state == ST_RUN) && !redirect_valid && w_credit_ok;
  assign imem_req    = w_issue && rst_n;
  assign imem_addr   = r_pc;

  assign w_push             = r_inflight && !r_kill && !redirect_valid;
  assign w_push_entry.instr = XLEN'(imem_rdata);
  assign w_push_entry.npc   = XLEN'(r_inflight_pc + ADDR_W'(1));

  // Handshake: the head transfers on any cycle where out_valid && out_ready
  // are both high; out_valid never depends on out_ready.
  assign w_pop     = out_valid && out_ready;
  assign out_valid = !w_empty;
  assign out_instr = out_valid ? DATA_W'(w_head.instr) : '0;
  assign out_npc   = out_valid ? ADDR_W'(w_head.npc)   : '0;
  assign count     = w_count;

`ifdef FETCH_HLT_STOP_EN
  assign w_hlt         = w_push && (opcode_of(w_push_entry.instr) == OPC_HLT);
  assign fetch_stopped = (r_state == ST_STOPPED);
`else
  assign w_hlt         = 1'b0;
  assign fetch_stopped = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
      r_state       <= ST_RUN;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      r_inflight <= w_issue;
      // The word fetched alongside an HLT response lands after the stop.
      r_kill     <= w_hlt && w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_W'(1);
        r_inflight_pc <= r_pc;
      end
      if (w_hlt) r_state <= ST_STOPPED;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk1),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: queue-level reference model plus
// directed literal scenarios and a randomized phase.
module tb_mips32_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_HLT_STOP_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [31:0]   out_npc;
  logic          fetch_stopped;
  logic [CW-1:0] count;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_npc        (out_npc),
    .fetch_stopped  (fetch_stopped),
    .count          (count)
  );

  // ---------------- instruction memory ----------------
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = a * 32'h9E3779B1;
    return {3'b000, a[2:0], h[25:0]};
  endfunction

  always @(posedge clk1) imem_rdata <= imem_req ? mem_rd(imem_addr) : $urandom;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending words as a queue of {instr, npc}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc, m_inf_pc;
  bit          m_inf, m_kill, m_stop;

  logic          o_req, o_valid, o_stop;
  logic [31:0]   o_addr, o_instr, o_npc;
  logic [CW-1:0] o_count;
  int            cyc;

  task automatic model_reset();
    m_pc = '0; m_inf_pc = '0; m_inf = 0; m_kill = 0; m_stop = 0;
    exp_q.delete();
  endtask

  task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit          e_req, e_valid, pop, resp, hlt;
    logic [63:0] head;
    logic [31:0] w;
    @(negedge clk1);
    out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    o_req = imem_req; o_addr = imem_addr; o_valid = out_valid; o_instr = out_instr;
    o_npc = out_npc; o_count = count; o_stop = fetch_stopped;

    e_req   = !m_stop && !rv && (exp_q.size() + int'(m_inf) < DEPTH);
    e_valid = exp_q.size() != 0;
    head    = e_valid ? exp_q[0] : 64'h0;
    check("imem_req", o_req, e_req);
    if (e_req) check("imem_addr", o_addr, m_pc);
    check("out_valid", o_valid, e_valid);
    check("out_instr", o_instr, head[63:32]);
    check("out_npc", o_npc, head[31:0]);
    check("count", o_count, exp_q.size());
    check("fetch_stopped", o_stop, m_stop);

    pop  = e_valid && rdy;
    resp = m_inf && !m_kill;
    if (rv) begin
      exp_q.delete();
      m_pc = rpc; m_stop = 0; m_inf = 0; m_kill = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      hlt = 0;
      if (resp) begin
        w = mem_rd(m_inf_pc);
        exp_q.push_back({w, m_inf_pc + 32'd1});
        hlt = HLT_EN && (w[31:26] == 6'h3f);
      end
      if (hlt) m_stop = 1;
      m_kill = hlt && e_req;
      m_inf  = e_req;
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd1;
      end
    end
    cyc++;
  endtask

  // Asserts reset at a falling edge, checks outputs at once, releases before E0.
  task automatic do_reset(input string tag);
    @(negedge clk1);
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    check({tag, "_rst_req"}, imem_req, 0);
    check({tag, "_rst_valid"}, out_valid, 0);
    check({tag, "_rst_instr"}, out_instr, 0);
    check({tag, "_rst_npc"}, out_npc, 0);
    check({tag, "_rst_count"}, count, 0);
    check({tag, "_rst_stopped"}, fetch_stopped, 0);
    model_reset();
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t_instr [4];
  int          n_out, max_addr;
  logic [31:0] last_npc;

  initial begin
    t_instr = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800};
    for (int i = 0; i < 4; i++) mem_ovr[i] = t_instr[i];

    // Basic stream
    do_reset("s1");
    for (int c = 0; c < 6; c++) begin
      tick(1, 0, 0);
      if (c == 0) check("s1_req_addr0", {o_req, o_addr}, {1'b1, 32'h0});
      if (c == 1) check("s1_valid_c1", o_valid, 0);
      if (c >= 2) check("s1_pair", {o_valid, o_instr, o_npc}, {1'b1, t_instr[c-2], 32'(c-1)});
    end

    // Back-pressure
    do_reset("s2");
    for (int c = 0; c < 10; c++) tick(0, 0, 0);
    check("s2_count_full", o_count, 4);
    check("s2_no_req_full", o_req, 0);
    for (int c = 0; c < 4; c++) begin
      tick(1, 0, 0);
      check("s2_drain", {o_valid, o_instr, o_npc}, {1'b1, t_instr[c], 32'(c+1)});
    end

    // Redirect with 3 buffered and 1 in flight
    do_reset("s3");
    for (int c = 0; c < 5; c++) tick(c == 2, 0, 0);
    tick(0, 1, 32'h40);
    check("s3_count_at_redirect", o_count, 3);
    tick(0, 0, 0);
    check("s3_valid_r1", o_valid, 0);
    check("s3_req_r1", {o_req, o_addr}, {1'b1, 32'h40});
    tick(1, 0, 0);
    check("s3_valid_r2", o_valid, 0);
    tick(1, 0, 0);
    check("s3_first_npc", {o_valid, o_npc}, {1'b1, 32'h41});

    // HLT stop (ordinary word when the feature is off)
    mem_ovr.delete();
    mem_ovr[7] = 32'hfc000000;
    do_reset("s4");
    n_out = 0; max_addr = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1, 0, 0);
      if (o_req && int'(o_addr) > max_addr) max_addr = int'(o_addr);
      if (o_valid) begin
        n_out++;
        check("s4_order", o_npc, n_out);
      end
    end
    check("s4_n_out", n_out, HLT_EN ? 8 : 18);
    check("s4_max_addr", max_addr, HLT_EN ? 8 : 19);
    check("s4_stopped", o_stop, HLT_EN);
    tick(1, 1, 32'h0);
    tick(1, 0, 0);
    check("s4_restart", {o_req, o_addr, o_stop}, {1'b1, 32'h0, 1'b0});

    // PC wrap
    mem_ovr.delete();
    do_reset("s5");
    repeat (3) tick(1, 0, 0);
    tick(1, 1, 32'hFFFF_FFFF);
    tick(1, 0, 0);
    check("s5_req_top", {o_req, o_addr}, {1'b1, 32'hFFFF_FFFF});
    tick(1, 0, 0);
    check("s5_req_wrap", {o_req, o_addr}, {1'b1, 32'h0});
    tick(1, 0, 0);
    check("s5_npc_wrap", {o_valid, o_npc}, {1'b1, 32'h0});

    // Reset mid-stream with a word in flight
    repeat (3) tick(1, 0, 0);
    do_reset("s6");
    tick(1, 0, 0);
    check("s6_restart", {o_req, o_addr}, {1'b1, 32'h0});

    // Randomized phase
    mem_ovr[20] = 32'hfc000001;
    mem_ovr[45] = 32'hfc123456;
    do_reset("rnd");
    for (int c = 0; c < 600; c++) begin
      bit          rdy, rv;
      logic [31:0] rpc;
      int          sel;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rpc = $urandom_range(0, 60);
        1:       rpc = 32'hFFFF_FFFC + $urandom_range(0, 3);
        2:       rpc = $urandom;
        default: rpc = $urandom_range(10, 50);
      endcase
      tick(rdy, rv, rpc);
      if (c == 300) do_reset("rnd_mid");
    end

    last_npc = o_npc;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
